// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared constants, types and helpers for the dmem access arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package dmem_arbiter_pkg;

  localparam int XLEN = `XLEN;

  // Loads and stores share encodings, so the names alias.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] AMP_NONE = 4'b0000;
  localparam logic [3:0] AMP_B0   = 4'b0001;
  localparam logic [3:0] AMP_H0   = 4'b0011;
  localparam logic [3:0] AMP_H1   = 4'b1100;
  localparam logic [3:0] AMP_W    = 4'b1111;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester (C, D) and dmem-side signal bundle for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic            c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [2:0]      c_funct3;
  logic [XLEN-1:0] c_addr, c_wdata, c_rdata;

  logic            d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]      d_funct3;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;

  logic            mem_we;
  logic [3:0]      mem_amp;
  logic [XLEN-1:0] mem_a, mem_wd, mem_rd;

  modport slave (
    input  c_req, c_we, c_funct3, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  d_req, d_we, d_funct3, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_we, mem_amp, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output c_req, c_we, c_funct3, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output d_req, d_we, d_funct3, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_we, mem_amp, mem_a, mem_wd,
    output mem_rd
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_lane.sv
// ============================================================================
// Module   : dmem_lane
// Brief    : Combinational byte-lane decoder: store mask, alignment, load extend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane
  import dmem_arbiter_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] mem_rd_i,
  output logic [3:0]      amp_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = mem_rd_i[7:0];
    case (addr_i)
      2'd1:    w_byte = mem_rd_i[15:8];
      2'd2:    w_byte = mem_rd_i[23:16];
      2'd3:    w_byte = mem_rd_i[31:24];
      default: w_byte = mem_rd_i[7:0];
    endcase
    w_half = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
  end

  // funct3[1:0] carries the access size for both loads and stores.
  always_comb begin
    misalign_o = 1'b0;
    amp_o      = AMP_NONE;
    case (funct3_i[1:0])
      2'b00: amp_o = AMP_B0 << addr_i;
      2'b01: begin
        misalign_o = addr_i[0];
        amp_o      = addr_i[1] ? AMP_H1 : AMP_H0;
      end
      2'b10: begin
        misalign_o = |addr_i;
        amp_o      = AMP_W;
      end
      default: amp_o = AMP_NONE;
    endcase
    if (!we_i) begin
      amp_o = AMP_NONE;
    end
  end

  always_comb begin
    case (funct3_i)
      F3_LB:   ldata_o = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   ldata_o = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LW:   ldata_o = mem_rd_i;
      F3_LBU:  ldata_o = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  ldata_o = {{(XLEN-16){1'b0}}, w_half};
      default: ldata_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (C pipeline, D debug/DMA) arbiter and decoder for dmem.
//            DMEM_ARB_RR_EN selects round-robin instead of C priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH_W  = 7,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rstn,
  dmem_arbiter_if.slave   bus_if
);

  port_e           w_win;
  logic            w_d_first;
  logic            w_c_gnt, w_d_gnt, w_any_gnt;
  logic            w_we, w_err, w_misalign, w_oor, w_wr;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_addr, w_wdata, w_ldata, w_resp;
  logic [3:0]      w_amp;

  logic            c_rvalid_q, c_err_q, d_rvalid_q, d_err_q;
  logic [XLEN-1:0] c_rdata_q, d_rdata_q;

`ifdef DMEM_ARB_RR_EN
  port_e ptr_q, ptr_d;

  assign w_d_first = (ptr_q == PORT_D);

  // Pointer always names the port that did not win the last grant.
  always_comb begin
    ptr_d = ptr_q;
    if (w_any_gnt) begin
      ptr_d = w_c_gnt ? PORT_D : PORT_C;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= PORT_C;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_q, wait_d;

  assign w_d_first = (wait_q == WAIT_MAX);

  // Saturates so D keeps its claim until the next contested cycle.
  always_comb begin
    wait_d = wait_q;
    if (!bus_if.d_req || w_d_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  always_comb begin
    w_win = PORT_C;
    if (bus_if.d_req && (!bus_if.c_req || w_d_first)) begin
      w_win = PORT_D;
    end
  end

  assign w_c_gnt   = rstn & bus_if.c_req & (w_win == PORT_C);
  assign w_d_gnt   = rstn & bus_if.d_req & (w_win == PORT_D);
  assign w_any_gnt = w_c_gnt | w_d_gnt;

  assign w_we    = (w_win == PORT_D) ? bus_if.d_we     : bus_if.c_we;
  assign w_f3    = (w_win == PORT_D) ? bus_if.d_funct3 : bus_if.c_funct3;
  assign w_addr  = (w_win == PORT_D) ? bus_if.d_addr   : bus_if.c_addr;
  assign w_wdata = (w_win == PORT_D) ? bus_if.d_wdata  : bus_if.c_wdata;

  dmem_lane u_lane (
    .funct3_i   (w_f3),
    .addr_i     (w_addr[1:0]),
    .we_i       (w_we),
    .mem_rd_i   (bus_if.mem_rd),
    .amp_o      (w_amp),
    .misalign_o (w_misalign),
    .ldata_o    (w_ldata)
  );

  assign w_oor  = |w_addr[XLEN-1:DEPTH_W+2];
  assign w_err  = f3_illegal(w_f3) | w_misalign | w_oor;
  assign w_wr   = w_any_gnt & w_we & ~w_err;
  assign w_resp = (w_we | w_err) ? '0 : w_ldata;

  assign bus_if.mem_we  = w_wr;
  assign bus_if.mem_amp = w_wr ? w_amp : AMP_NONE;
  assign bus_if.mem_a   = {{(XLEN-DEPTH_W){1'b0}}, w_addr[DEPTH_W+1:2]};
  assign bus_if.mem_wd  = w_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= w_c_gnt;
      d_rvalid_q <= w_d_gnt;
      if (w_c_gnt) begin
        c_err_q   <= w_err;
        c_rdata_q <= w_resp;
      end
      if (w_d_gnt) begin
        d_err_q   <= w_err;
        d_rdata_q <= w_resp;
      end
    end
  end

  assign bus_if.c_gnt    = w_c_gnt;
  assign bus_if.d_gnt    = w_d_gnt;
  assign bus_if.c_rvalid = c_rvalid_q;
  assign bus_if.d_rvalid = d_rvalid_q;
  assign bus_if.c_err    = c_err_q;
  assign bus_if.d_err    = d_err_q;
  assign bus_if.c_rdata  = c_rdata_q;
  assign bus_if.d_rdata  = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DEPTH_W  = 7;
  localparam int MAX_WAIT = 8;
  localparam int NWORDS   = 1 << DEPTH_W;
  localparam int NBYTES   = 4 * NWORDS;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH_W(DEPTH_W), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_if (bus)
  );

  // dmem stand-in: combinational read, clocked lane write, plus a backdoor port
  logic [31:0]        dmem [NWORDS];
  logic               bd_we = 1'b0;
  logic [DEPTH_W-1:0] bd_idx;
  logic [31:0]        bd_val;
  logic [DEPTH_W-1:0] mi;

  assign mi         = bus.mem_a[DEPTH_W-1:0];
  assign bus.mem_rd = dmem[mi];

  always @(posedge clk) begin
    if (bd_we) begin
      dmem[bd_idx] <= bd_val;
    end else if (bus.mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_amp[i]) begin
          if (bus.mem_amp == 4'b1111)
            dmem[mi][8*i +: 8] <= bus.mem_wd[8*i +: 8];
          else if (bus.mem_amp == 4'b0011 || bus.mem_amp == 4'b1100)
            dmem[mi][8*i +: 8] <= bus.mem_wd[8*(i%2) +: 8];
          else
            dmem[mi][8*i +: 8] <= bus.mem_wd[7:0];
        end
      end
    end
  end

  // Reference model state
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  bmem [NBYTES];
`ifdef DMEM_ARB_RR_EN
  int          ref_ptr;
`else
  int          ref_wait;
`endif
  logic [31:0] hold_c_rdata, hold_d_rdata;
  logic        hold_c_err, hold_d_err;
  logic        exp_cg, exp_dg;
  int          dut_d_gnts;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (a >= NBYTES) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int          n;
    logic [31:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(bmem[a + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) bmem[a + i] = wd[8*i +: 8];
  endtask

  task automatic model_reset();
`ifdef DMEM_ARB_RR_EN
    ref_ptr = 0;
`else
    ref_wait = 0;
`endif
    hold_c_rdata = '0;
    hold_d_rdata = '0;
    hold_c_err   = 1'b0;
    hold_d_err   = 1'b0;
  endtask

  // One clock: check grant/decode mid-cycle, responses just after the edge.
  task automatic tick();
    logic        d_first, we, e, pc_v, pd_v;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdv;
    logic [3:0]  m;
    @(negedge clk);
`ifdef DMEM_ARB_RR_EN
    d_first = (ref_ptr == 1);
`else
    d_first = (ref_wait >= MAX_WAIT);
`endif
    exp_dg = bus.d_req && (!bus.c_req || d_first);
    exp_cg = bus.c_req && !exp_dg;
    chk1("c_gnt", bus.c_gnt, exp_cg);
    chk1("d_gnt", bus.d_gnt, exp_dg);
    if (bus.d_gnt) dut_d_gnts++;
    pc_v = 1'b0;
    pd_v = 1'b0;
    rdv  = '0;
    e    = 1'b0;
    if (exp_cg || exp_dg) begin
      we = exp_dg ? bus.d_we     : bus.c_we;
      f3 = exp_dg ? bus.d_funct3 : bus.c_funct3;
      a  = exp_dg ? bus.d_addr   : bus.c_addr;
      wd = exp_dg ? bus.d_wdata  : bus.c_wdata;
      e  = ref_err(f3, a);
      m  = (we && !e) ? ref_mask(f3, a) : 4'b0000;
      chk1("mem_we", bus.mem_we, we && !e);
      chk32("mem_amp", 32'(bus.mem_amp), 32'(m));
      chk32("mem_a", bus.mem_a, (a >> 2) % NWORDS);
      chk32("mem_wd", bus.mem_wd, wd);
      rdv = (we || e) ? 32'd0 : ref_load(f3, a);
      if (we && !e) ref_store(f3, a, wd);
      pc_v = exp_cg;
      pd_v = exp_dg;
    end else begin
      chk1("idle_mem_we", bus.mem_we, 1'b0);
      chk32("idle_mem_amp", 32'(bus.mem_amp), 32'd0);
    end
`ifdef DMEM_ARB_RR_EN
    if (exp_cg) ref_ptr = 1;
    else if (exp_dg) ref_ptr = 0;
`else
    if (!bus.d_req || exp_dg) ref_wait = 0;
    else if (ref_wait < MAX_WAIT) ref_wait++;
`endif
    @(posedge clk);
    #1;
    if (pc_v) begin hold_c_rdata = rdv; hold_c_err = e; end
    if (pd_v) begin hold_d_rdata = rdv; hold_d_err = e; end
    chk1("c_rvalid", bus.c_rvalid, pc_v);
    chk1("d_rvalid", bus.d_rvalid, pd_v);
    chk32("c_rdata", bus.c_rdata, hold_c_rdata);
    chk32("d_rdata", bus.d_rdata, hold_d_rdata);
    chk1("c_err", bus.c_err, hold_c_err);
    chk1("d_err", bus.d_err, hold_d_err);
  endtask

  task automatic set_c(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.c_req = 1'b1; bus.c_we = we; bus.c_funct3 = f3; bus.c_addr = a; bus.c_wdata = wd;
  endtask

  task automatic set_d(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_funct3 = f3; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  task automatic preload(input int w, input logic [31:0] val);
    bd_we  = 1'b1;
    bd_idx = DEPTH_W'(w);
    bd_val = val;
    for (int i = 0; i < 4; i++) bmem[4*w + i] = val[8*i +: 8];
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic rand_req(input bit is_d);
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;
    f3  = 3'($urandom_range(0, 7));
    sel = $urandom_range(0, 9);
    if (sel == 0)     a = NBYTES + $urandom_range(0, 1023);
    else if (sel < 5) a = $urandom_range(0, 63);
    else              a = $urandom_range(0, NBYTES - 1);
    if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
    if (is_d) set_d(1'($urandom_range(0, 1)), f3, a, $urandom);
    else      set_c(1'($urandom_range(0, 1)), f3, a, $urandom);
  endtask

  initial begin
    bus.c_req = 0; bus.c_we = 0; bus.c_funct3 = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_funct3 = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bd_idx = '0;
    bd_val = '0;
    dut_d_gnts = 0;
    for (int i = 0; i < NBYTES; i++) bmem[i] = 8'h00;
    model_reset();

    #1 rstn = 1'b0;
    #1;
    chk1("rst_c_rvalid", bus.c_rvalid, 1'b0);
    chk1("rst_d_rvalid", bus.d_rvalid, 1'b0);
    chk32("rst_c_rdata", bus.c_rdata, 32'd0);
    chk1("rst_c_err", bus.c_err, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    for (int w = 0; w < NWORDS; w++) preload(w, 32'd0);
    rstn = 1'b1;

    // Halfword store into the upper half of word 1
    set_c(1'b1, F3_SH, 32'h6, 32'h0000_BEEF);
    tick();
    bus.c_req = 1'b0;
    chk1("sh_err", bus.c_err, 1'b0);

    // Load extension on a preloaded word
    preload(2, 32'h80FF_7F01);
    set_c(1'b0, F3_LB, 32'h9, 32'd0);  tick(); chk32("lb_9", bus.c_rdata, 32'h0000_007F);
    set_c(1'b0, F3_LBU, 32'hA, 32'd0); tick(); chk32("lbu_A", bus.c_rdata, 32'h0000_00FF);
    set_c(1'b0, F3_LH, 32'hA, 32'd0);  tick(); chk32("lh_A", bus.c_rdata, 32'hFFFF_80FF);
    set_c(1'b0, F3_LHU, 32'hA, 32'd0); tick(); chk32("lhu_A", bus.c_rdata, 32'h0000_80FF);
    bus.c_req = 1'b0;

    // Misaligned store and out-of-range load
    set_c(1'b1, F3_SW, 32'h5, 32'hDEAD_BEEF); tick();
    chk1("sw_mis_err", bus.c_err, 1'b1);
    set_c(1'b0, F3_LW, 32'h200, 32'd0); tick();
    bus.c_req = 1'b0;
    chk1("lw_oor_err", bus.c_err, 1'b1);
    chk32("lw_oor_rdata", bus.c_rdata, 32'd0);

    // Store by C followed immediately by D reading it back
    set_c(1'b1, F3_SW, 32'h10, 32'h1234_5678); tick(); bus.c_req = 1'b0;
    set_d(1'b0, F3_LW, 32'h10, 32'd0);         tick(); bus.d_req = 1'b0;
    chk32("raw_d_rdata", bus.d_rdata, 32'h1234_5678);

    // Reset asserted while a load is being granted
    set_c(1'b0, F3_LW, 32'h8, 32'd0);
    set_d(1'b0, F3_LW, 32'h24, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk1("mid_rst_c_gnt", bus.c_gnt, 1'b0);
    chk1("mid_rst_d_gnt", bus.d_gnt, 1'b0);
    chk32("mid_rst_c_rdata", bus.c_rdata, 32'd0);
    chk32("mid_rst_d_rdata", bus.d_rdata, 32'd0);
    chk1("mid_rst_mem_we", bus.mem_we, 1'b0);
    chk32("mid_rst_mem_amp", 32'(bus.mem_amp), 32'd0);
    @(posedge clk);
    #1;
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    rstn = 1'b1;
    model_reset();
    tick();

    // Continuous contention for 27 cycles
    dut_d_gnts = 0;
    set_c(1'b0, F3_LW, 32'h20, 32'd0);
    set_d(1'b0, F3_LW, 32'h24, 32'd0);
    for (int k = 0; k < 27; k++) tick();
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
`ifdef DMEM_ARB_RR_EN
    chk32("contend_d_gnts", 32'(dut_d_gnts), 32'd13);
`else
    chk32("contend_d_gnts", 32'(dut_d_gnts), 32'd3);
`endif

    // Random traffic, each request held until its grant
    for (int k = 0; k < 400; k++) begin
      if (!bus.c_req && $urandom_range(0, 2) != 0) rand_req(1'b0);
      if (!bus.d_req && $urandom_range(0, 2) != 0) rand_req(1'b1);
      tick();
      if (exp_cg) bus.c_req = 1'b0;
      if (exp_dg) bus.d_req = 1'b0;
    end
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    for (int w = 0; w < NWORDS; w++)
      chk32("mem_image", dmem[w], {bmem[4*w+3], bmem[4*w+2], bmem[4*w+1], bmem[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester access controller for the single-port data memory: port C (pipeline load/store unit) and port D (debug/DMA).
- Arbitrates requests, decodes funct3 plus byte address into the memory's word address and byte-lane mask, and checks alignment and range.
- Sign/zero-extends load data and returns registered responses one cycle after grant.
- Sits between the MEM stage and dmem; dmem reads combinationally and writes on the clock edge.

Parameters:
- DEPTH_W, 7, word-index width of dmem (128 words); byte addresses at or above 4*2^DEPTH_W are out of range.
- MAX_WAIT, 8, cycles a pending D request may be refused before it gets forced priority.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous reset, active low.
- c_req/d_req  in  1  request; held stable until gnt.
- c_we/d_we  in  1  1 = store, 0 = load.
- c_funct3/d_funct3  in  3  RISC-V load/store funct3.
- c_addr/d_addr  in  `XLEN  byte address.
- c_wdata/d_wdata  in  `XLEN  store data, unshifted (byte/half data in low bits).
- c_gnt/d_gnt  out  1  one-cycle accept pulse.
- c_rvalid/d_rvalid  out  1  response valid, exactly 1 cycle after gnt.
- c_rdata/d_rdata  out  `XLEN  extended load data; 0 for stores and errors.
- c_err/d_err  out  1  misaligned, illegal funct3 or out-of-range; qualified by rvalid.
- mem_we  out  1  dmem write enable.
- mem_amp  out  4  dmem byte-lane mask.
- mem_a  out  `XLEN  word address = {zeros, byte_addr[DEPTH_W+1:2]}.
- mem_wd  out  `XLEN  write data = winner wdata, passed unshifted; dmem places the low byte/half itself.
- mem_rd  in  `XLEN  dmem read data (combinational).

Behaviour:
- Reset: all gnt, rvalid, err, mem_we = 0; rdata = 0; mem_amp = 0; wait counter = 0; rr pointer = C.
- Grant:
  - At most one gnt per cycle; it is combinational from req and arbitration state.
  - The winner's decoded access drives mem_* in the same cycle, and the store commits at that posedge.
  - Loads sample mem_rd at that posedge.
- Throughput: back-to-back grants allowed every cycle, to either port.
- Default priority: C wins.
- Starvation counter:
  - Increments each cycle d_req=1 and d_gnt=0.
  - Clears on d_gnt or when d_req=0.
  - When it reaches MAX_WAIT, D wins the next contested cycle, then the counter clears.
- Lane mask:
  - sb: 0001/0010/0100/1000 for addr[1:0] = 0/1/2/3.
  - sh: 0011 for addr[1]=0, 1100 for addr[1]=1.
  - sw: 1111.
  - Loads drive mem_amp = 0000.
- Errors:
  - Half access with addr[0]=1, word access with addr[1:0]≠0, funct3 in {011,110,111}, or addr ≥ 4*2^DEPTH_W.
  - The request is still granted, but mem_we is forced to 0.
  - Next cycle: rvalid=1, err=1, rdata=0.
- Load extension (applied to the lane selected by addr[1:0]): lb sign-extends the byte, lh sign-extends the half, lw passes the word, lbu/lhu zero-extend.
- Response: rvalid pulses 1 cycle on the granted port only. rdata/err hold their value until the next response on that port.
- Idle: when no gnt, mem_we=0 and mem_amp=0; mem_a and mem_wd are don't-care but driven from port C.
- Reset mid-operation: a pending response is dropped (no rvalid after rstn rises), and the counter and pointer reset.
- Store response: rvalid=1, err=0, rdata=0.

Optional Feature:
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - The pointer flips to the other port after each grant.
  - The contested winner is the pointer port; the starvation counter is not instantiated.
- Undefined: fixed C priority with the MAX_WAIT starvation escape described above.

Decomposition:
- Shared package/defines (extend xgriscv_defines.v):
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - amp mask constants.
  - `XLEN.
- Sub-module dmem_lane: combinational decoder. Inputs: funct3, addr[1:0], we, mem_rd. Outputs: amp, misalign flag, extended load data. Instantiated once on the winner path.
- Arbitration, counter and response registers stay in the top.

Test Plan:
- Reset: rstn=0 mid-traffic → all outputs 0 asynchronously; no rvalid in the cycle after release.
- C sh, addr=0x0000_0006, wdata=0x0000_BEEF → mem_amp=1100, mem_a=1, mem_we=1; next cycle c_rvalid=1, err=0.
- Preload word 2 = 0x80FF_7F01; C lb at 0x9 → rdata 0x0000_007F; lbu at 0xA → 0x0000_00FF; lh at 0xA → 0xFFFF_80FF; lhu at 0xA → 0x0000_80FF.
- Misaligned sw at 0x5, and lw at 0x200 (out of range for DEPTH_W=7) → gnt=1, mem_we=0, next-cycle err=1, rdata=0; memory contents unchanged.
- C and D request continuously with fixed priority → D granted exactly once per MAX_WAIT+1 (=9) cycles. With DMEM_ARB_RR_EN → grants alternate C, D, C, D.
- Back-to-back C sw 0x1234_5678 at 0x10, then D lw 0x10 in the next cycle → d_rdata=0x1234_5678 one cycle after d_gnt.
